// File: rtl/blinky.sv
// Free-running blink divider: led is the MSB of a WIDTH-bit up-counter.
// The counter clears asynchronously on rst and counts on every rising clk edge.
module blinky #(
  parameter int WIDTH = 24
) (
  input  logic clk,
  input  logic rst,
  output logic led
);

  logic [WIDTH-1:0] r_cnt;

  // Natural modulo-2^WIDTH wrap; no terminal-count handling needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Straight from the flop, so led cannot glitch.
  assign led = r_cnt[WIDTH-1];

endmodule

// File: tb/tb_blinky.sv
// Directed bench for blinky at WIDTH=4, 1 and 24, with a queue-based scoreboard
// of per-cycle expected led/cnt values produced by a reference counter model.
module tb_blinky;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4 = 1'b0;
  logic rst1 = 1'b0;
  logic rst24 = 1'b0;
  logic led4, led1, led24;

  blinky #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst4),  .led(led4));
  blinky #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst1),  .led(led1));
  blinky #(.WIDTH(24)) dut24 (.clk(clk), .rst(rst24), .led(led24));

  typedef struct {
    int          id;
    logic [23:0] exp;
  } sb_t;

  sb_t sb[$];
  int n_assert = 0;
  int n_fail = 0;

  logic [3:0]  m4;
  logic        m1;
  logic [23:0] m24;

  function automatic string tag_of(input int id);
    case (id)
      0: return "led4";
      1: return "cnt4";
      2: return "led1";
      3: return "led24";
      default: return "cnt24";
    endcase
  endfunction

  function automatic logic [23:0] obs(input int id);
    case (id)
      0: return 24'(led4);
      1: return 24'(dut4.r_cnt);
      2: return 24'(led1);
      3: return 24'(led24);
      default: return dut24.r_cnt;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, o, e, $time);
    end
  endtask

  task automatic push_expected();
    sb.push_back('{0, 24'(m4[3])});
    sb.push_back('{1, 24'(m4)});
    sb.push_back('{2, 24'(m1)});
    sb.push_back('{3, 24'(m24[23])});
    sb.push_back('{4, m24});
  endtask

  task automatic drain();
    sb_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag_of(e.id), obs(e.id), e.exp);
    end
  endtask

  // One clock cycle: advance the model, queue expectations, sample after the edge.
  task automatic step();
    if (!rst4)  m4  = m4 + 4'd1;
    if (!rst1)  m1  = ~m1;
    if (!rst24) m24 = m24 + 24'd1;
    push_expected();
    @(posedge clk);
    #1;
    drain();
  endtask

  logic prev;
  int   run_len;
  int   rises;
  int   rise_t;
  int   fall_t;

  initial begin
    m4 = '0; m1 = 1'b0; m24 = '0;
    rst4 = 1'b1; rst1 = 1'b1; rst24 = 1'b1;

    // Reset takes effect with no clock edge yet.
    #2;
    push_expected();
    drain();

    // Held in reset across edges at 5 and 15.
    step();
    step();

    #4;
    rst4 = 1'b0; rst1 = 1'b0; rst24 = 1'b0;

    // 100 cycles of free running; measure led4 intervals from release.
    prev = 1'b0; run_len = 1; rises = 0; rise_t = -1; fall_t = -1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (led4 === prev) begin
        run_len++;
      end else begin
        chk("interval4", 24'(run_len), 24'd8);
        if (led4 === 1'b1) begin
          rises++;
          if (rise_t < 0) rise_t = int'($time) - 1;
        end else if (fall_t < 0) begin
          fall_t = int'($time) - 1;
        end
        run_len = 1;
        prev = led4;
      end
    end
    chk("rises4", 24'(rises), 24'd6);
    chk("first_rise_t", 24'(rise_t), 24'd95);
    chk("first_fall_t", 24'(fall_t), 24'd175);

    // Run until led4 is high, then reset it mid-cycle.
    for (int i = 0; i < 20 && m4[3] != 1'b1; i++) step();
    chk("led4_high_before_rst", 24'(led4), 24'd1);
    #2;
    rst4 = 1'b1;
    m4 = '0;
    #1;
    chk("led4_async_rst", 24'(led4), 24'd0);
    chk("cnt4_async_rst", 24'(dut4.r_cnt), 24'd0);
    @(negedge clk);
    step();
    step();
    @(negedge clk);
    rst4 = 1'b0;
    // Low for 7 more edges after release, high on the 8th.
    for (int i = 0; i < 10; i++) step();

    // Reset coincident with a rising edge wins over the increment.
    @(posedge clk);
    rst4 = 1'b1;
    m4 = '0;
    m1 = ~m1;
    m24 = m24 + 24'd1;
    #1;
    push_expected();
    drain();
    @(negedge clk);
    rst4 = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // WIDTH=24 boundary: preload the counter just below the MSB flip.
    @(negedge clk);
    force dut24.r_cnt = 24'h7FFFFE;
    #1;
    release dut24.r_cnt;
    m24 = 24'h7FFFFE;
    push_expected();
    drain();
    step();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
